isqrt_arbiter: RTL and testbench
================================

ISQRT_ARBITER -- requirements
Module: isqrt_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning number of requesters (2..8).
REQ-002 The block SHALL have parameter X_WIDTH, default 32, meaning operand width (even).
REQ-003 The block SHALL have parameter TMO_CYC, default X_WIDTH/2+4, meaning engine watchdog limit in cycles.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 The block SHALL have port req_valid  input  N_REQ  per-requester operand valid.
REQ-007 The block SHALL have port req_x  input  N_REQ*X_WIDTH  packed operands, requester i at bits [i*X_WIDTH +: X_WIDTH].
REQ-008 The block SHALL have port req_ready  output  N_REQ  one-hot accept strobe; operand i taken when req_valid[i] && req_ready[i].
REQ-009 The block SHALL have port rsp_valid  output  1  result available.
REQ-010 The block SHALL have port rsp_id  output  3  index of requester owning result.
REQ-011 The block SHALL have port rsp_y  output  X_WIDTH/2  square-root result.
REQ-012 The block SHALL have port rsp_err  output  1  result invalid (watchdog expiry), qualified by rsp_valid.
REQ-013 The block SHALL have port rsp_ready  input  1  consumer accepts result when rsp_valid && rsp_ready.
REQ-014 The block SHALL have port sq_en  output  1  engine start strobe.
REQ-015 The block SHALL have port sq_x  output  X_WIDTH  engine operand.
REQ-016 The block SHALL have port sq_y  input  X_WIDTH/2  engine result.
REQ-017 The block SHALL have port sq_dav  input  1  engine one-cycle done strobe, nominally X_WIDTH/2+1 cycles after the sq_en cycle.

Function
REQ-018 The FSM SHALL have states IDLE, LAUNCH, WAIT, RESP.
REQ-019 IDLE: if any req_valid, grant highest-priority valid requester g, assert req_ready[g] that cycle, register req_x slice g into sq_x and g into rsp_id, go LAUNCH; otherwise stay, req_ready = 0.
REQ-020 Priority SHALL be round-robin: pointer p; search order p, p+1, ... mod N_REQ; after grant to g, p <= (g+1) mod N_REQ.
REQ-021 LAUNCH: sq_en = 1 for exactly one cycle, clear watchdog counter, go WAIT.
REQ-022 WAIT: sq_en = 0; on sq_dav capture sq_y into rsp_y, rsp_err <= 0, go RESP.
REQ-023 WAIT: watchdog counts cycles; when count reaches TMO_CYC without sq_dav, rsp_y <= 0, rsp_err <= 1, go RESP.
REQ-024 RESP: rsp_valid = 1, rsp_id/rsp_y/rsp_err stable; on rsp_ready go IDLE; no new grant in the same cycle (minimum 1 IDLE cycle between jobs).
REQ-025 sq_dav outside WAIT SHALL be ignored.
REQ-026 req_ready SHALL be zero in all states except IDLE and at most one bit set.
REQ-027 sq_x SHALL hold the granted operand from LAUNCH until the next grant.
REQ-028 Only one job outstanding; end-to-end latency from grant to rsp_valid = 1 + 1 + (X_WIDTH/2+1) cycles with nominal engine.

Reset
REQ-029 On rst_n low: state IDLE, p = 0, req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_y = 0, rsp_err = 0, sq_en = 0, sq_x = 0, watchdog = 0, immediately (asynchronous).
REQ-030 Reset mid-job SHALL abandon the job with no response; first post-reset grant follows priority from p = 0.

Verification
REQ-031 Single request: req_valid=0001, req_x[0]=144 -> req_ready=0001 one cycle, one sq_en pulse, rsp_valid with rsp_id=0, rsp_y=12, rsp_err=0.
REQ-032 Contention: all four valid continuously, x_i=i*i+... -> grants in order 0,1,2,3,0; each rsp_id matches grant, rsp_y = isqrt(x_i).
REQ-033 Backpressure: rsp_ready held 0 for 10 cycles in RESP -> rsp_valid/rsp_y stable, req_ready stays 0, no sq_en.
REQ-034 Watchdog: engine model never asserts sq_dav -> after TMO_CYC WAIT cycles rsp_valid=1, rsp_err=1, rsp_y=0.
REQ-035 Reset in WAIT: rst_n low 2 cycles -> all outputs 0 at once; afterwards req 2 and 0 valid -> requester 0 granted first.
REQ-036 Boundaries: x=0 -> y=0; x=2^32-1 -> y=65535; spurious sq_dav in IDLE -> no response.

Source files
------------

// File: rtl/isqrt_arbiter.sv
// rtl/isqrt_arbiter.sv - round-robin front end sharing one external isqrt engine among N_REQ requesters
// One job in flight at a time, with a watchdog that turns a silent engine into an error response.
module isqrt_arbiter #(
  parameter int N_REQ   = 4,
  parameter int X_WIDTH = 32,
  parameter int TMO_CYC = X_WIDTH/2 + 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*X_WIDTH-1:0] req_x,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     rsp_valid,
  output logic [2:0]               rsp_id,
  output logic [X_WIDTH/2-1:0]     rsp_y,
  output logic                     rsp_err,
  input  logic                     rsp_ready,
  output logic                     sq_en,
  output logic [X_WIDTH-1:0]       sq_x,
  input  logic [X_WIDTH/2-1:0]     sq_y,
  input  logic                     sq_dav
);

  localparam int YW = X_WIDTH/2;
  localparam int WW = $clog2(TMO_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         id_q, id_d;
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic               err_q, err_d;
  logic [WW-1:0]      wdog_q, wdog_d;

  logic               gnt_found;
  logic [2:0]         gnt_idx;
  logic [X_WIDTH-1:0] gnt_x;

  // Round-robin: first look at indices >= ptr, then wrap to the low indices.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_x     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid[i] && (i >= int'(ptr_q))) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(i);
        gnt_x     = req_x[i*X_WIDTH +: X_WIDTH];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!gnt_found && req_valid[i]) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(i);
        gnt_x     = req_x[i*X_WIDTH +: X_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    x_d       = x_q;
    y_d       = y_q;
    err_d     = err_q;
    wdog_d    = wdog_q;
    req_ready = '0;
    sq_en     = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Gating with rst_n keeps req_ready low while reset holds us in IDLE.
        if (gnt_found && rst_n) begin
          req_ready = N_REQ'(1) << gnt_idx;
          x_d       = gnt_x;
          id_d      = gnt_idx;
          ptr_d     = (gnt_idx == 3'(N_REQ-1)) ? 3'd0 : gnt_idx + 3'd1;
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        sq_en   = 1'b1;
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (sq_dav) begin
          y_d     = sq_y;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (wdog_q == WW'(TMO_CYC-1)) begin
          y_d     = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      x_q     <= x_d;
      y_q     <= y_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
    end
  end

  assign rsp_id  = id_q;
  assign rsp_y   = y_q;
  assign rsp_err = err_q;
  assign sq_x    = x_q;

endmodule

// File: tb/tb_isqrt_arbiter.sv
// tb/tb_isqrt_arbiter.sv - directed-vector bench for isqrt_arbiter with a behavioural engine
module tb_isqrt_arbiter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_x = '0;
  logic [3:0]   req_ready;
  logic         rsp_valid;
  logic [2:0]   rsp_id;
  logic [15:0]  rsp_y;
  logic         rsp_err;
  logic         rsp_ready = 1'b0;
  logic         sq_en;
  logic [31:0]  sq_x;
  logic [15:0]  sq_y = '0;
  logic         sq_dav;
  logic         eng_dav = 1'b0;
  logic         spur_dav = 1'b0;
  logic         eng_on = 1'b1;

  int checks = 0;
  int errors = 0;
  int eng_cnt = 0;
  logic [31:0] eng_x = '0;
  int en_cnt = 0;
  int onehot_bad = 0;
  int glog[$];

  assign sq_dav = eng_dav | spur_dav;

  isqrt_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_x(req_x), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .sq_en(sq_en), .sq_x(sq_x), .sq_y(sq_y), .sq_dav(sq_dav)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] isqrt32(input logic [31:0] x);
    logic [63:0] r;
    logic [63:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, x}) r = t;
    end
    return r[15:0];
  endfunction

  // Engine: done strobe 17 cycles after the sq_en cycle.
  always @(negedge clk) begin
    eng_dav = 1'b0;
    if (!rst_n) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_dav = 1'b1;
          sq_y    = isqrt32(eng_x);
        end
      end
      if (sq_en && eng_on) begin
        eng_cnt = 17;
        eng_x   = sq_x;
      end
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if ($countones(req_ready) > 1) onehot_bad++;
      for (int i = 0; i < 4; i++) if (req_ready[i] && req_valid[i]) glog.push_back(i);
      if (sq_en) en_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_seen", rsp_valid, 1);
  endtask

  task automatic accept();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic set_x(input int i, input logic [31:0] v);
    req_x[i*32 +: 32] = v;
  endtask

  initial begin
    int lat;
    int en0;
    int bp_bad;
    int seen;
    logic [2:0]  exp_id [5];
    logic [15:0] exp_y  [5];

    // Reset values, with requests pending to exercise req_ready gating.
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_y", rsp_y, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_sq_en", sq_en, 0);
    check("rst_sq_x", sq_x, 0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request: 144 -> 12, latency 19 from grant.
    en0 = en_cnt;
    set_x(0, 32'd144);
    req_valid = 4'b0001;
    #1;
    check("single_ready", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("single_ready_drop", req_ready, 0);
    wait_valid(lat);
    check("single_latency", lat + 1, 19);
    check("single_id", rsp_id, 0);
    check("single_y", rsp_y, 12);
    check("single_err", rsp_err, 0);
    check("single_sq_en_cnt", en_cnt - en0, 1);
    accept();

    // Backpressure on a max operand; requester 1 waits meanwhile.
    set_x(2, 32'hFFFF_FFFF);
    req_valid = 4'b0100;
    #1;
    check("bp_grant2", req_ready, 4'b0100);
    @(negedge clk);
    req_valid = '0;
    wait_valid(lat);
    set_x(1, 32'd17);
    req_valid = 4'b0010;
    en0 = en_cnt;
    bp_bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_y !== 16'hFFFF || rsp_id !== 3'd2 ||
          rsp_err !== 1'b0 || req_ready !== 4'b0 || sq_en !== 1'b0) bp_bad++;
    end
    check("bp_stable", bp_bad, 0);
    check("bp_no_sq_en", en_cnt - en0, 0);
    check("bp_y_max", rsp_y, 16'hFFFF);
    rsp_ready = 1'b1;
    #1;
    check("bp_no_grant_in_resp", req_ready, 0);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("bp_next_grant1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    wait_valid(lat);
    check("bp_job1_id", rsp_id, 1);
    check("bp_job1_y", rsp_y, 4);
    accept();

    // Reset during WAIT abandons the job; pointer restarts at 0.
    set_x(1, 32'd9);
    req_valid = 4'b0010;
    #1;
    check("rw_grant1", req_ready, 4'b0010);
    @(negedge clk);
    req_valid = '0;
    repeat (5) @(negedge clk);
    set_x(0, 32'd0);
    set_x(2, 32'd100);
    req_valid = 4'b0101;
    #1;
    rst_n = 1'b0;
    #1;
    check("rw_req_ready", req_ready, 0);
    check("rw_rsp_valid", rsp_valid, 0);
    check("rw_rsp_id", rsp_id, 0);
    check("rw_rsp_y", rsp_y, 0);
    check("rw_sq_en", sq_en, 0);
    check("rw_sq_x", sq_x, 0);
    repeat (2) @(negedge clk);
    glog.delete();
    rst_n = 1'b1;
    #1;
    check("rw_first_grant", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    wait_valid(lat);
    check("rw_latency", lat + 1, 19);
    check("rw_id", rsp_id, 0);
    check("rw_y_zero", rsp_y, 0);
    check("rw_one_grant", glog.size(), 1);
    accept();

    // Watchdog: silent engine gives an error after 20 WAIT cycles.
    eng_on = 1'b0;
    set_x(3, 32'd50);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    wait_valid(lat);
    check("wd_latency", lat + 1, 22);
    check("wd_id", rsp_id, 3);
    check("wd_err", rsp_err, 1);
    check("wd_y", rsp_y, 0);
    accept();
    eng_on = 1'b1;

    // Spurious done strobe in IDLE.
    @(negedge clk);
    spur_dav = 1'b1;
    @(negedge clk);
    spur_dav = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("spur_no_rsp", seen, 0);

    // Contention from a fresh reset: grants 0,1,2,3,0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    glog.delete();
    set_x(0, 32'd1);
    set_x(1, 32'd17);
    set_x(2, 32'd100);
    set_x(3, 32'd1000);
    exp_id = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    exp_y  = '{16'd1, 16'd4, 16'd10, 16'd31, 16'd1};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_valid(lat);
      check($sformatf("ct_id%0d", k), rsp_id, exp_id[k]);
      check($sformatf("ct_y%0d", k), rsp_y, exp_y[k]);
      accept();
    end
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("ct_grant_cnt", glog.size(), 5);
    for (int k = 0; k < 5 && k < glog.size(); k++)
      check($sformatf("ct_grant%0d", k), glog[k], exp_id[k]);
    check("onehot_ready", onehot_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
